// File: rtl/aq_axis_seq_checker.sv
// aq_axis_seq_checker: AXI4-Stream sink that checks an incrementing data
// sequence and TLAST framing, counts beats/packets/errors and captures the
// first data mismatch.
// Optional build macro: AQ_AXIS_CHK_BP_EN adds LFSR-driven random backpressure.
//
// Handshake: a beat is accepted on a rising edge where S_AXIS_TVALID and
// S_AXIS_TREADY are both 1. TREADY is decoded only from registered state
// (and the LFSR when enabled), never from any input, so it is stable for the
// whole cycle. All results appear on the outputs the cycle after the
// accepting edge.
module aq_axis_seq_checker #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  S_AXIS_ACLK,
  input  logic                  RST_N,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  input  logic                  S_AXIS_TLAST,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                  CHK_ENABLE,
  input  logic                  CHK_CLEAR,
  input  logic [DATA_WIDTH-1:0] CHK_START_VALUE,
  input  logic [15:0]           CHK_PKT_LEN,
  output logic                  CHK_BUSY,
  output logic [31:0]           BEAT_COUNT,
  output logic [31:0]           PKT_COUNT,
  output logic [15:0]           ERR_DATA_COUNT,
  output logic [15:0]           ERR_LAST_COUNT,
  output logic                  ERR_FLAG,
  output logic [DATA_WIDTH-1:0] ERR_EXP,
  output logic [DATA_WIDTH-1:0] ERR_GOT,
  output logic [1:0]            DBG_STATE
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] exp_data_q, exp_data_d;
  logic [15:0]           idx_q, idx_d;
  logic [31:0]           beat_cnt_q, beat_cnt_d;
  logic [31:0]           pkt_cnt_q, pkt_cnt_d;
  logic [15:0]           err_data_q, err_data_d;
  logic [15:0]           err_last_q, err_last_d;
  logic                  err_flag_q, err_flag_d;
  logic [DATA_WIDTH-1:0] err_exp_q, err_exp_d;
  logic [DATA_WIDTH-1:0] err_got_q, err_got_d;

  logic        active;
  logic        ready;
  logic        beat;
  logic        data_err;
  logic        last_err;
  logic        at_end;
  logic [15:0] len_m1;

  // Beat decode and error detection against the current expected word/index.
  always_comb begin
    active   = (state_q != ST_IDLE);
    len_m1   = CHK_PKT_LEN - 16'd1;
    at_end   = (CHK_PKT_LEN != 16'd0) && (idx_q == len_m1);
    beat     = S_AXIS_TVALID && ready;
    data_err = beat && (S_AXIS_TDATA != exp_data_q);
    last_err = beat && (CHK_PKT_LEN != 16'd0) && (S_AXIS_TLAST != at_end);
  end

`ifdef AQ_AXIS_CHK_BP_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR (taps 16,14,13,11) that steps only while the sink is active.
  always_comb begin
    lfsr_d = lfsr_q;
    if (active) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    ready = active && (lfsr_q[1:0] != 2'b00);
  end

  // LFSR register.
  always_ff @(posedge S_AXIS_ACLK or negedge RST_N) begin
    if (!RST_N) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end
`else
  // Without backpressure the sink is ready whenever it is active.
  always_comb begin
    ready = active;
  end
`endif

  // Next state, expected word and packet index.
  always_comb begin
    state_d    = state_q;
    exp_data_d = exp_data_q;
    idx_d      = idx_q;
    if (beat) begin
      // Resync on the received word so a single bad word counts once.
      exp_data_d = S_AXIS_TDATA + DATA_ONE;
      idx_d      = (S_AXIS_TLAST || at_end) ? 16'd0 : idx_q + 16'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (CHK_ENABLE) begin
          state_d    = ST_RUN;
          exp_data_d = CHK_START_VALUE;
          idx_d      = 16'd0;
        end
      end
      ST_RUN: begin
        if (!CHK_ENABLE) state_d = (idx_q == 16'd0) ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (beat && S_AXIS_TLAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters, sticky flag and first-error capture; clear beats any update.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    err_data_d = err_data_q;
    err_last_d = err_last_q;
    err_flag_d = err_flag_q;
    err_exp_d  = err_exp_q;
    err_got_d  = err_got_q;
    if (CHK_CLEAR) begin
      beat_cnt_d = 32'd0;
      pkt_cnt_d  = 32'd0;
      err_data_d = 16'd0;
      err_last_d = 16'd0;
      err_flag_d = 1'b0;
      err_exp_d  = '0;
      err_got_d  = '0;
    end else if (beat) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
      if (S_AXIS_TLAST) pkt_cnt_d = pkt_cnt_q + 32'd1;
      if (data_err && (err_data_q != 16'hFFFF)) err_data_d = err_data_q + 16'd1;
      if (last_err && (err_last_q != 16'hFFFF)) err_last_d = err_last_q + 16'd1;
      if (data_err || last_err) err_flag_d = 1'b1;
      if (data_err && !err_flag_q) begin
        err_exp_d = exp_data_q;
        err_got_d = S_AXIS_TDATA;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge S_AXIS_ACLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      exp_data_q <= '0;
      idx_q      <= 16'd0;
      beat_cnt_q <= 32'd0;
      pkt_cnt_q  <= 32'd0;
      err_data_q <= 16'd0;
      err_last_q <= 16'd0;
      err_flag_q <= 1'b0;
      err_exp_q  <= '0;
      err_got_q  <= '0;
    end else begin
      state_q    <= state_d;
      exp_data_q <= exp_data_d;
      idx_q      <= idx_d;
      beat_cnt_q <= beat_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_data_q <= err_data_d;
      err_last_q <= err_last_d;
      err_flag_q <= err_flag_d;
      err_exp_q  <= err_exp_d;
      err_got_q  <= err_got_d;
    end
  end

  assign S_AXIS_TREADY  = ready;
  assign CHK_BUSY       = active;
  assign BEAT_COUNT     = beat_cnt_q;
  assign PKT_COUNT      = pkt_cnt_q;
  assign ERR_DATA_COUNT = err_data_q;
  assign ERR_LAST_COUNT = err_last_q;
  assign ERR_FLAG       = err_flag_q;
  assign ERR_EXP        = err_exp_q;
  assign ERR_GOT        = err_got_q;
  assign DBG_STATE      = state_q;

endmodule

// File: tb/tb_aq_axis_seq_checker.sv
// tb_aq_axis_seq_checker: randomized and directed bench for aq_axis_seq_checker
// with a behavioural model of the checker's counting/error rules.
// Build with AQ_AXIS_CHK_BP_EN to exercise the backpressure variant.
module tb_aq_axis_seq_checker;

  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [DW-1:0] s_tdata;
  logic          chk_enable;
  logic          chk_clear;
  logic [DW-1:0] chk_start;
  logic [15:0]   chk_len;
  logic          chk_busy;
  logic [31:0]   beat_count;
  logic [31:0]   pkt_count;
  logic [15:0]   err_data_count;
  logic [15:0]   err_last_count;
  logic          err_flag;
  logic [DW-1:0] err_exp;
  logic [DW-1:0] err_got;
  logic [1:0]    dbg_state;

  aq_axis_seq_checker #(.DATA_WIDTH(DW)) dut (
    .S_AXIS_ACLK     (clk),
    .RST_N           (rst_n),
    .S_AXIS_TVALID   (s_tvalid),
    .S_AXIS_TREADY   (s_tready),
    .S_AXIS_TLAST    (s_tlast),
    .S_AXIS_TDATA    (s_tdata),
    .CHK_ENABLE      (chk_enable),
    .CHK_CLEAR       (chk_clear),
    .CHK_START_VALUE (chk_start),
    .CHK_PKT_LEN     (chk_len),
    .CHK_BUSY        (chk_busy),
    .BEAT_COUNT      (beat_count),
    .PKT_COUNT       (pkt_count),
    .ERR_DATA_COUNT  (err_data_count),
    .ERR_LAST_COUNT  (err_last_count),
    .ERR_FLAG        (err_flag),
    .ERR_EXP         (err_exp),
    .ERR_GOT         (err_got),
    .DBG_STATE       (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int            n_cmp = 0;
  int            n_err = 0;
  int            stall_n = 0;
  logic [DW-1:0] exp_q[$];
  logic [31:0]   m_beats, m_pkts;
  logic [15:0]   m_ed, m_el;
  logic          m_flag;
  logic [DW-1:0] m_eexp, m_egot;
  int            m_idx;
  int            m_len;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_beats = 0; m_pkts = 0; m_ed = 0; m_el = 0;
    m_flag = 1'b0; m_eexp = '0; m_egot = '0;
  endtask

  task automatic model_reset();
    model_clear();
    m_idx = 0;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  task automatic model_start(input logic [DW-1:0] start, input int len);
    m_len = len;
    m_idx = 0;
    exp_q.delete();
    exp_q.push_back(start);
  endtask

  // One accepted beat: the data must follow the previous word by one; TLAST
  // must sit on the last slot of every m_len-beat packet.
  task automatic model_beat(input logic [DW-1:0] d, input logic l, input logic clr);
    logic [DW-1:0] e;
    logic          derr, lerr, want_last;
    e         = exp_q.pop_front();
    derr      = (d != e);
    exp_q.push_back(d + 1);
    want_last = (m_len != 0) && (m_idx == m_len - 1);
    lerr      = (m_len != 0) && (l != want_last);
    m_idx     = (l || want_last) ? 0 : m_idx + 1;
    if (clr) begin
      model_clear();
    end else begin
      m_beats = m_beats + 1;
      if (l) m_pkts = m_pkts + 1;
      if (derr && !m_flag) begin
        m_eexp = e;
        m_egot = d;
      end
      if (derr && m_ed != 16'hFFFF) m_ed = m_ed + 1;
      if (lerr && m_el != 16'hFFFF) m_el = m_el + 1;
      if (derr || lerr) m_flag = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_beats"}, beat_count, m_beats);
    check({tag, "_pkts"}, pkt_count, m_pkts);
    check({tag, "_errd"}, err_data_count, m_ed);
    check({tag, "_errl"}, err_last_count, m_el);
    check({tag, "_flag"}, err_flag, m_flag);
    check({tag, "_eexp"}, err_exp, m_eexp);
    check({tag, "_egot"}, err_got, m_egot);
  endtask

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  task automatic send(input logic [DW-1:0] d, input logic l, input logic clr);
    int n;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    while (!s_tready && n < 64) begin
      stall_n++;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!s_tready) begin
      check("handshake_timeout", 64'd0, 64'd1);
      s_tvalid = 1'b0;
    end else begin
      chk_clear = clr;
      @(posedge clk);
      model_beat(d, l, clr);
      @(negedge clk);
      s_tvalid  = 1'b0;
      s_tlast   = 1'b0;
      chk_clear = 1'b0;
    end
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic pulse_clear();
    chk_clear = 1'b1;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    chk_clear = 1'b0;
  endtask

  task automatic enable_run(input logic [DW-1:0] start, input int len);
    chk_start  = start;
    chk_len    = 16'(len);
    chk_enable = 1'b1;
    @(posedge clk);
    model_start(start, len);
    @(negedge clk);
    check("enable_busy", chk_busy, 1'b1);
  endtask

  // Only used with the packet index at 0, so RUN goes straight to IDLE.
  task automatic disable_run();
    chk_enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("disable_busy", chk_busy, 1'b0);
    check("disable_ready", s_tready, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] g;
    int            len, plen, npk;
    logic          l, c;
    logic [DW-1:0] d;

    rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    chk_enable = 1'b0; chk_clear = 1'b0; chk_start = '0; chk_len = '0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready", s_tready, 1'b0);
    check("rst_busy", chk_busy, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    check_all("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Clean 20-beat stream, packets of 4
    pulse_clear();
    enable_run(32'd0, 4);
    for (int i = 0; i < 20; i++) begin
      gap();
      send(i, (i % 4) == 3, 1'b0);
    end
    check("t1_beats", beat_count, 32'd20);
    check("t1_pkts", pkt_count, 32'd5);
    check("t1_errd", err_data_count, 16'd0);
    check("t1_errl", err_last_count, 16'd0);
    check("t1_flag", err_flag, 1'b0);
    check_all("t1");
`ifdef AQ_AXIS_CHK_BP_EN
    check("t1_bp_stalls_seen", 64'(stall_n > 0), 64'd1);
`endif
    disable_run();

    // Single bad word resyncs and counts once
    pulse_clear();
    enable_run(32'd0, 1);
    send(32'd0, 1'b1, 1'b0);
    send(32'd1, 1'b1, 1'b0);
    send(32'd7, 1'b1, 1'b0);
    send(32'd8, 1'b1, 1'b0);
    send(32'd9, 1'b1, 1'b0);
    check("t2_errd", err_data_count, 16'd1);
    check("t2_eexp", err_exp, 32'd2);
    check("t2_egot", err_got, 32'd7);
    check("t2_errl", err_last_count, 16'd0);
    check_all("t2");
    disable_run();

    // TLAST missing on slot 3, late on the next beat
    pulse_clear();
    enable_run(32'd0, 4);
    for (int i = 0; i < 5; i++) send(i, i == 4, 1'b0);
    check("t3_errl", err_last_count, 16'd2);
    check("t3_pkts", pkt_count, 32'd1);
    check("t3_errd", err_data_count, 16'd0);
    for (int i = 5; i < 9; i++) send(i, i == 8, 1'b0);
    check("t3_errl_after", err_last_count, 16'd2);
    check("t3_pkts_after", pkt_count, 32'd2);
    check_all("t3");
    disable_run();

    // Data wrap at all-ones
    pulse_clear();
    enable_run(32'hFFFF_FFFE, 0);
    send(32'hFFFF_FFFE, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 1'b0, 1'b0);
    send(32'h0000_0000, 1'b0, 1'b0);
    send(32'h0000_0001, 1'b1, 1'b0);
    check("t4_errd", err_data_count, 16'd0);
    check("t4_beats", beat_count, 32'd4);
    check("t4_flag", err_flag, 1'b0);
    disable_run();

    // Enable dropped mid-packet: drain until TLAST
    pulse_clear();
    enable_run(32'd0, 4);
    for (int i = 0; i < 3; i++) send(i, 1'b0, 1'b0);
    chk_enable = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("t5_drain_busy", chk_busy, 1'b1);
      check("t5_drain_state", dbg_state, 2'd2);
`ifndef AQ_AXIS_CHK_BP_EN
      check("t5_drain_ready", s_tready, 1'b1);
`endif
    end
    send(32'd3, 1'b1, 1'b0);
    check("t5_idle_busy", chk_busy, 1'b0);
    check("t5_idle_ready", s_tready, 1'b0);
    check("t5_idle_state", dbg_state, 2'd0);
    check_all("t5");

    // Clear on the same cycle as an accepted beat
    pulse_clear();
    enable_run(32'd0, 4);
    send(32'd0, 1'b0, 1'b0);
    send(32'd1, 1'b0, 1'b0);
    send(32'd2, 1'b0, 1'b1);
    check("t6_beats", beat_count, 32'd0);
    check("t6_pkts", pkt_count, 32'd0);
    check("t6_flag", err_flag, 1'b0);
    send(32'd3, 1'b1, 1'b0);
    check("t6_beats_after", beat_count, 32'd1);
    check("t6_errd_after", err_data_count, 16'd0);
    check("t6_errl_after", err_last_count, 16'd0);
    disable_run();

    // Randomized sessions against the model
    for (int s = 0; s < 6; s++) begin
      len = $urandom_range(0, 6);
      g   = $urandom;
      if ($urandom_range(0, 1) == 0) pulse_clear();
      enable_run(g, len);
      npk = $urandom_range(2, 5);
      for (int p = 0; p < npk; p++) begin
        plen = (len != 0) ? len : $urandom_range(1, 5);
        for (int b = 0; b < plen; b++) begin
          d = g;
          g = g + 1;
          if ($urandom_range(0, 7) == 0) d = $urandom;
          l = (b == plen - 1);
          if ($urandom_range(0, 9) == 0) l = ~l;
          if (p == npk - 1 && b == plen - 1) l = 1'b1;
          c = ($urandom_range(0, 15) == 0);
          gap();
          send(d, l, c);
          check_all("rnd");
        end
      end
      disable_run();
    end

    // Reset in the middle of a packet
    enable_run(32'd100, 4);
    send(32'd100, 1'b0, 1'b0);
    send(32'd105, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_ready", s_tready, 1'b0);
    check("mid_rst_busy", chk_busy, 1'b0);
    check_all("mid_rst");
    chk_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_state", dbg_state, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    n_err++;
    $display("FAIL global_timeout: got running expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
